// File: rtl/uart_out_router_if.sv
// Bus between the shared TX FIFO, the router and the per-port UART transmitters.
// master = router side, slave = FIFO/transmitter side.
interface uart_out_router_if #(
  parameter int UART_COUNT = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_read;
  logic [UART_COUNT-1:0] tx_busy;
  logic [UART_COUNT-1:0] write;
  logic [DATA_WIDTH-1:0] data;
  logic                  frame_error;
  logic                  active;

  modport master (
    input  fifo_empty, fifo_data, tx_busy,
    output fifo_read, write, data, frame_error, active
  );

  modport slave (
    output fifo_empty, fifo_data, tx_busy,
    input  fifo_read, write, data, frame_error, active
  );
endinterface

// File: rtl/uart_out_router.sv
// Drains framed traffic ([chan][len][payload]) from a FWFT byte FIFO and
// steers payload bytes to one of UART_COUNT transmitters; bad channels are dropped.
module uart_out_router #(
  parameter int UART_COUNT = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  uart_out_router_if.master bus
);
  localparam int CH_BITS = (UART_COUNT > 1) ? $clog2(UART_COUNT) : 1;
  localparam int CW      = DATA_WIDTH + 1;

  typedef enum logic [2:0] {
    S_CHAN, S_LEN, S_DATA, S_GAP, S_DROP_LEN, S_DROP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CH_BITS-1:0]    ch_q, ch_d;
  logic [UART_COUNT-1:0] write_q, write_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  fe_q, fe_d;
  logic                  active_q;
  logic                  pop, avail, ch_ok, ch_busy, last;
  logic [CW-1:0]         len_val;

  // Full byte compared, so any upper bit set marks the channel invalid.
  assign ch_ok   = 32'(bus.fifo_data) < 32'(UART_COUNT);
  assign ch_busy = bus.tx_busy[ch_q];
  assign avail   = !bus.fifo_empty && !reset;
  assign last    = (count_q == CW'(1));
  assign len_val = (bus.fifo_data == '0) ? {1'b1, {DATA_WIDTH{1'b0}}}
                                         : {1'b0, bus.fifo_data};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ch_d    = ch_q;
    write_d = '0;
    data_d  = data_q;
    fe_d    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_CHAN: if (avail) begin
        pop = 1'b1;
        if (ch_ok) begin
          ch_d    = bus.fifo_data[CH_BITS-1:0];
          state_d = S_LEN;
        end else begin
          fe_d    = 1'b1;
          state_d = S_DROP_LEN;
        end
      end
      S_LEN, S_DROP_LEN: if (avail) begin
        pop     = 1'b1;
        count_d = len_val;
        state_d = (state_q == S_LEN) ? S_DATA : S_DROP;
      end
      S_DATA: if (avail && !ch_busy) begin
        pop           = 1'b1;
        write_d[ch_q] = 1'b1;
        data_d        = bus.fifo_data;
        count_d       = count_q - CW'(1);
        state_d       = last ? S_CHAN : S_GAP;
      end
      // Idle cycle lets the transmitter raise tx_busy before the next byte.
      S_GAP: state_d = S_DATA;
      S_DROP: if (avail) begin
        pop     = 1'b1;
        count_d = count_q - CW'(1);
        if (last) state_d = S_CHAN;
      end
      default: state_d = S_CHAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_CHAN;
      count_q  <= '0;
      ch_q     <= '0;
      write_q  <= '0;
      data_q   <= '0;
      fe_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ch_q     <= ch_d;
      write_q  <= write_d;
      data_q   <= data_d;
      fe_q     <= fe_d;
      active_q <= (state_d != S_CHAN);
    end
  end

  assign bus.fifo_read   = pop;
  assign bus.write       = write_q;
  assign bus.data        = data_q;
  assign bus.frame_error = fe_q;
  assign bus.active      = active_q;
endmodule

// File: tb/tb_uart_out_router.sv
// Directed bench: queue-backed FWFT FIFO model, write/pop logs, hand-computed expectations.
module tb_uart_out_router;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_out_router_if #(.UART_COUNT(4), .DATA_WIDTH(8)) bus ();
  uart_out_router #(.UART_COUNT(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [7:0] q[$];
  logic [3:0] wmask[$];
  logic [7:0] wdata[$];
  int         wcyc[$];
  int         pcyc[$];
  logic [7:0] pbyte[$];
  int cyc = 0, fe = 0, rd_bad = 0;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic upd();
    bus.fifo_empty = (q.size() == 0);
    bus.fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic clr();
    wmask.delete(); wdata.delete(); wcyc.delete();
    pcyc.delete();  pbyte.delete(); fe = 0;
  endtask

  // One clock: pop if strobed, then log registered outputs of the new cycle.
  task automatic tick();
    logic       pend;
    logic [7:0] pb;
    @(posedge clk);
    pend = bus.fifo_read;
    pb   = bus.fifo_data;
    #1;
    if (pend) begin
      if (q.size() == 0) rd_bad++;
      else void'(q.pop_front());
      pcyc.push_back(cyc);
      pbyte.push_back(pb);
    end
    cyc++;
    upd();
    if (bus.write != '0) begin
      wmask.push_back(bus.write);
      wdata.push_back(bus.data);
      wcyc.push_back(cyc);
    end
    if (bus.frame_error) fe++;
  endtask

  task automatic run_writes(input int n, input int budget);
    int b;
    b = budget;
    while (wmask.size() < n && b > 0) begin
      tick();
      b--;
    end
    chk("nwrites", wmask.size(), n);
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    upd();
  endtask

  initial begin
    int errs, w, n0;
    reset = 1'b1;
    bus.tx_busy = 4'b0000;
    upd();
    repeat (3) tick();
    chk("rst_outs", {bus.fifo_read, bus.write, bus.data, bus.frame_error, bus.active}, 0);
    reset = 1'b0;
    tick();

    // basic frame: ch2, 3 bytes
    clr();
    push(8'h02); push(8'h03); push(8'hAA); push(8'hBB); push(8'hCC);
    run_writes(3, 40);
    chk("t1_mask", {wmask[0], wmask[1], wmask[2]}, {4'b0100, 4'b0100, 4'b0100});
    chk("t1_data", {wdata[0], wdata[1], wdata[2]}, 24'hAABBCC);
    chk("t1_gap", {16'(wcyc[1] - wcyc[0]), 16'(wcyc[2] - wcyc[1])}, {16'd2, 16'd2});
    chk("t1_lat", wcyc[0] - pcyc[2], 1);
    chk("t1_payload_pop", pbyte[2], 8'hAA);
    tick();
    chk("t1_active", bus.active, 1'b0);
    chk("t1_fe", fe, 0);

    // bad channel 07 dropped, then good frame to ch0
    clr();
    push(8'h07); push(8'h02); push(8'h11); push(8'h22);
    push(8'h00); push(8'h01); push(8'h55);
    run_writes(1, 40);
    chk("t2_wr", {wmask[0], wdata[0]}, {4'b0001, 8'h55});
    chk("t2_fe", fe, 1);
    chk("t2_pops", pcyc.size(), 7);

    // backpressure on ch1; busy on ch0 must be ignored
    clr();
    bus.tx_busy = 4'b0001;
    push(8'h01); push(8'h02); push(8'h10); push(8'h20);
    run_writes(1, 40);
    w = wcyc[0];
    bus.tx_busy = 4'b0011;
    n0 = pcyc.size();
    repeat (10) tick();
    chk("t3_nopop", pcyc.size(), n0);
    bus.tx_busy = 4'b0001;
    run_writes(2, 20);
    chk("t3_wr", {wmask[0], wdata[0], wmask[1], wdata[1]}, {4'b0010, 8'h10, 4'b0010, 8'h20});
    chk("t3_stall", wcyc[1] - w, 11);
    bus.tx_busy = 4'b0000;

    // length 0 means 256 payload bytes
    clr();
    push(8'h00); push(8'h00);
    for (int i = 0; i < 256; i++) push(8'(i));
    run_writes(256, 1200);
    errs = 0;
    for (int i = 0; i < wmask.size(); i++)
      if (wmask[i] != 4'b0001 || wdata[i] != 8'(i)) errs++;
    chk("t4_seq", errs, 0);
    chk("t4_last", wdata[wdata.size()-1], 8'hFF);
    tick();
    chk("t4_idle", {bus.active, 8'(q.size())}, 9'h0);
    repeat (3) tick();
    chk("t4_no_extra", wmask.size(), 256);

    // FIFO underrun mid-frame
    clr();
    push(8'h03); push(8'h02); push(8'hAA);
    run_writes(1, 20);
    w  = wcyc[0];
    n0 = pcyc.size();
    repeat (5) tick();
    chk("t5_hold", {8'(pcyc.size() - n0), 8'(wmask.size()), 7'd0, bus.active}, {8'd0, 8'd1, 8'd1});
    push(8'hBB);
    run_writes(2, 20);
    chk("t5_wr", {wmask[1], wdata[1]}, {4'b1000, 8'hBB});
    chk("t5_stall", wcyc[1] - w, 6);
    chk("t5_rd_bad", rd_bad, 0);

    // reset during S_DATA: leftover 02 01 becomes a fresh header
    clr();
    push(8'h01); push(8'h03); push(8'h11); push(8'h02); push(8'h01);
    run_writes(1, 20);
    chk("t6_first", {wmask[0], wdata[0]}, {4'b0010, 8'h11});
    bus.tx_busy = 4'b0010;
    tick(); tick();
    chk("t6_pre", {bus.data, 7'd0, bus.active}, {8'h11, 8'h01});
    reset = 1'b1;
    #1;
    chk("t6_rst", {bus.fifo_read, bus.write, bus.data, bus.frame_error, bus.active}, 0);
    tick(); tick();
    chk("t6_rst_hold", {bus.fifo_read, bus.write, bus.data, bus.frame_error, bus.active}, 0);
    chk("t6_q", q.size(), 2);
    reset = 1'b0;
    bus.tx_busy = 4'b0000;
    clr();
    push(8'h5A);
    run_writes(1, 20);
    chk("t6_wr", {wmask[0], wdata[0]}, {4'b0100, 8'h5A});
    tick();
    chk("t6_end", {8'(fe), 7'd0, bus.active, 8'(q.size())}, 24'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
